// File: rtl/load_store_unit.sv
// Load/store sequencer: turns one RV32I load/store request into single-byte,
// little-endian memory accesses (one byte per cycle) and returns the
// sign- or zero-extended load result as a one-cycle response pulse.
module load_store_unit #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [2:0]               req_funct3,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic                     resp_err,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [7:0]               mem_wd,
  output logic                     mem_we,
  input  logic [7:0]               mem_rd
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic                     we_q;
  logic [2:0]               f3_q;
  logic [1:0]               idx_q;
  logic                     err_q;
  logic [ADDRESS_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0]    wdata_q;
  logic [DATA_WIDTH-1:0]    acc_q;
  logic                     accept;

  // 011, 11x, and the unsigned encodings on a store have no meaning.
  function automatic logic illegal_f3(input logic we, input logic [2:0] f3);
    return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (we && f3[2]);
  endfunction

  // Index of the final byte: B/BU -> 0, H/HU -> 1, W -> 3.
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   return 2'd0;
      2'b01:   return 2'd1;
      default: return 2'd3;
    endcase
  endfunction

  // Widen the assembled bytes according to the load size and signedness.
  function automatic logic [DATA_WIDTH-1:0] extend(input logic [2:0] f3,
                                                   input logic [DATA_WIDTH-1:0] acc);
    case (f3)
      3'b000:  return {{(DATA_WIDTH-8){acc[7]}}, acc[7:0]};
      3'b001:  return {{(DATA_WIDTH-16){acc[15]}}, acc[15:0]};
      3'b100:  return {{(DATA_WIDTH-8){1'b0}}, acc[7:0]};
      3'b101:  return {{(DATA_WIDTH-16){1'b0}}, acc[15:0]};
      default: return acc;
    endcase
  endfunction

  assign accept = (state == IDLE) && req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; an illegal request skips straight to the response.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = illegal_f3(req_we, req_funct3) ? DONE : ACCESS;
      ACCESS:  if (idx_q == last_idx(f3_q)) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Control registers: request kind, byte index and error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q  <= 1'b0;
      f3_q  <= 3'b000;
      idx_q <= 2'd0;
      err_q <= 1'b0;
    end else if (accept) begin
      we_q  <= req_we;
      f3_q  <= req_funct3;
      idx_q <= 2'd0;
      err_q <= illegal_f3(req_we, req_funct3);
    end else if (state == ACCESS) begin
      idx_q <= idx_q + 2'd1;
    end
  end

  // Datapath registers: latched address/store data and the load accumulator.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
      acc_q   <= '0;
    end else if ((state == ACCESS) && !we_q) begin
      acc_q[{idx_q, 3'b000} +: 8] <= mem_rd;
    end
  end

  // Outputs; everything is forced quiet while rst is high so a reset
  // mid-store stops further byte writes in the same cycle.
  always_comb begin
    req_ready  = (state == IDLE) && !rst;
    mem_addr   = '0;
    mem_we     = 1'b0;
    mem_wd     = 8'h00;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    if (!rst) begin
      if (state == ACCESS) begin
        mem_addr = addr_q + ADDRESS_WIDTH'(idx_q);
        mem_we   = we_q;
        mem_wd   = we_q ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;
      end else if (state == DONE) begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = (err_q || we_q) ? '0 : extend(f3_q, acc_q);
      end
    end
  end

endmodule
